red_target_tracker: RTL and testbench
=====================================

// Module: red_target_tracker
// PURPOSE
//  Upstream feeder for the VGA pixel mixer. Scans the incoming RGB444 pixel stream once per frame.
//  Screen is split into a fixed 4x4 grid of 16 tiles (160x120 each). In each tile the block
//  accumulates a bounding box of "red" pixels. At frame end it publishes, per tile:
//  aim_x_all / aim_y_all / aim_detected_all and box_{x,y}_{min,max}_all.
// PARAMETERS
//  H_RES       640    active width; pixels with x >= H_RES are ignored
//  V_RES       480    active height; pixels with y >= V_RES are ignored
//  R_MIN       4'hA   red if R >= R_MIN
//  G_MAX       4'h5   ... and G <= G_MAX
//  B_MAX       4'h5   ... and B <= B_MAX
//  MIN_PIXELS  64     red-pixel count required for a tile to report detected
//  CNT_W       15     per-tile counter width; counter saturates at 2^CNT_W-1
// PORTS
//  clk               in   1         system clock; single clock domain
//  reset             in   1         synchronous, active-high reset
//  pixel_valid       in   1         pixel_data/x_pixel/y_pixel valid this cycle
//  pixel_data        in   12        RGB444 {R[11:8],G[7:4],B[3:0]}
//  x_pixel           in   10        column of pixel_data
//  y_pixel           in   10        row of pixel_data
//  frame_end         in   1         one-cycle pulse after the last pixel of a frame
//  aim_x_all         out  [15:0][9:0]   per-tile bbox centre x
//  aim_y_all         out  [15:0][9:0]   per-tile bbox centre y
//  aim_detected_all  out  16            per-tile detected flag
//  box_x_min_all     out  [15:0][11:0]  per-tile bbox min x
//  box_x_max_all     out  [15:0][11:0]  per-tile bbox max x
//  box_y_min_all     out  [15:0][11:0]  per-tile bbox min y
//  box_y_max_all     out  [15:0][11:0]  per-tile bbox max y
//  frame_done        out  1         one-cycle pulse when the outputs above have just updated
// BEHAVIOUR
//  - Reset: every output is 0; frame_done is 0.
//    Working regs per tile: xmin=ymin=12'hFFF, xmax=ymax=0, cnt=0. Pipeline valids cleared.
//  - Stage 1 (registered):
//    - is_red = valid & in-range & threshold test.
//    - tile = row*4+col, where col = x/160 and row = y/120, computed by compare (no divider).
//    - x, y and frame_end are registered alongside.
//  - Stage 2, for tile k when is_red:
//    - xmin=min(xmin,x), xmax=max(xmax,x), ymin=min(ymin,y), ymax=max(ymax,y).
//    - cnt = sat(cnt+1).
//    - Coordinates are zero-extended to 12 bits.
//  - Publish on the stage-2 frame_end cycle, for every tile:
//    - Pixel in the same cycle as frame_end belongs to the closing frame; its update is merged
//      into the published values.
//    - If merged cnt >= MIN_PIXELS: detected=1, boxes = merged bbox,
//      aim_x = (xmin+xmax)>>1 (11-bit sum, keep low 10 bits), aim_y likewise.
//    - Else: detected=0, box and aim all 0.
//    - Working regs return to their reset values in the same cycle.
//  - Latency: frame_end at cycle N -> outputs and frame_done at cycle N+2.
//    Outputs hold stable until the next publish.
//  - Non-red, invalid or out-of-range pixels: no state change.
//    The count saturates and never wraps.
//  - Back-to-back frame_end (no pixels in between): every tile publishes detected=0.
//  - Reset mid-frame: partial accumulation discarded; a frame_end in flight in the pipeline is dropped.
// STRUCTURE
//  - target_pkg holds:
//    - NUM_TARGETS=16, TILE_W=160, TILE_H=120
//    - colour-threshold defaults
//    - typedef bbox_t {x_min,x_max,y_min,y_max:12b}
//  - Sub-module tile_bbox_accum (one instance per tile; 16 instances).
//    - Inputs: hit, x, y, publish.
//    - Outputs: bbox_t, cnt, and the merged values used for publish.
//  - Top level holds the stage-1 classifier/tile decode and packs the output arrays.
// TESTING
//  1. Reset -> all outputs 0, frame_done=0. Then frame_end with no pixels -> frame_done
//     at +2 cycles, aim_detected_all=16'h0.
//  2. 10x10 block of 12'hF00 at x=300..309, y=200..209, then frame_end ->
//     - tile 5 detected (100 px >= 64)
//     - box 300/309/200/209
//     - aim (304,204)
//     - all other tiles 0
//  3. 7x9=63 red pixels in tile 0, then frame_end -> aim_detected_all[0]=0, box 0.
//     Add one more pixel in the frame_end cycle -> detected=1.
//  4. Pixels 12'hF88 (G over threshold), plus x=640 and pixel_valid=0 red pixels -> no tile updates.
//  5. Straddle block x=155..164, y=0..9 -> tile 0 box x 155..159 (50 px) not detected.
//     With a 12-row block (60 px per tile) also not detected. With a 14x14 block ->
//     - tile 0 box x 155..159
//     - tile 1 box x 160..168 (5/9 cols)
//     - both tiles detected (70 px and 126 px)
//  6. Assert reset in the middle of case 2's frame, then frame_end -> tile 5 not detected.
//     Next full frame publishes correctly.

Source files
------------

// File: rtl/target_pkg.sv
// Shared types and constants for the red target tracker: tile grid geometry,
// colour-threshold defaults and the bounding-box record carried per tile.
package target_pkg;

    localparam int NUM_TARGETS = 16;
    localparam int TILE_W      = 160;
    localparam int TILE_H      = 120;
    localparam int COORD_W     = 12;
    localparam int TILE_IDX_W  = 4;

    localparam logic [3:0] R_MIN_DEF = 4'hA;
    localparam logic [3:0] G_MAX_DEF = 4'h5;
    localparam logic [3:0] B_MAX_DEF = 4'h5;

    typedef struct packed {
        logic [COORD_W-1:0] x_min;
        logic [COORD_W-1:0] x_max;
        logic [COORD_W-1:0] y_min;
        logic [COORD_W-1:0] y_max;
    } bbox_t;

    // Inverted box so the first hit in a frame overwrites every edge.
    localparam bbox_t BBOX_EMPTY = '{
        x_min: {COORD_W{1'b1}},
        x_max: {COORD_W{1'b0}},
        y_min: {COORD_W{1'b1}},
        y_max: {COORD_W{1'b0}}
    };

    function automatic logic is_red_rgb444(
        input logic [11:0] rgb,
        input logic [3:0]  r_min,
        input logic [3:0]  g_max,
        input logic [3:0]  b_max
    );
        return (rgb[11:8] >= r_min) && (rgb[7:4] <= g_max) && (rgb[3:0] <= b_max);
    endfunction

    // Grid column/row index by comparison against tile multiples; avoids a divider.
    function automatic logic [1:0] grid_index(input int coord, input int tile_size);
        if (coord >= 3 * tile_size) begin
            return 2'd3;
        end else if (coord >= 2 * tile_size) begin
            return 2'd2;
        end else if (coord >= tile_size) begin
            return 2'd1;
        end
        return 2'd0;
    endfunction

    function automatic logic [9:0] bbox_centre(
        input logic [COORD_W-1:0] lo,
        input logic [COORD_W-1:0] hi
    );
        return 10'(({1'b0, lo} + {1'b0, hi}) >> 1);
    endfunction

endpackage

// File: rtl/tile_bbox_accum.sv
// Per-tile bounding-box and red-pixel counter; exposes the box/count including
// this cycle's hit so a pixel arriving with frame_end lands in the closing frame.
module tile_bbox_accum
    import target_pkg::*;
#(
    parameter int CNT_W = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hit,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               publish,
    output bbox_t              merged_bbox,
    output logic [CNT_W-1:0]   merged_cnt
);

    bbox_t            bbox_q, bbox_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        merged_bbox = bbox_q;
        merged_cnt  = cnt_q;
        if (hit) begin
            if (x < bbox_q.x_min) merged_bbox.x_min = x;
            if (x > bbox_q.x_max) merged_bbox.x_max = x;
            if (y < bbox_q.y_min) merged_bbox.y_min = y;
            if (y > bbox_q.y_max) merged_bbox.y_max = y;
            // Saturate rather than wrap so a huge blob never looks empty.
            if (cnt_q != {CNT_W{1'b1}}) merged_cnt = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        bbox_d = merged_bbox;
        cnt_d  = merged_cnt;
        if (publish) begin
            bbox_d = BBOX_EMPTY;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bbox_q <= BBOX_EMPTY;
            cnt_q  <= '0;
        end else begin
            bbox_q <= bbox_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/red_target_tracker.sv
// Scans an RGB444 pixel stream, tracks a red bounding box in each of 16 tiles
// (4x4 grid) and publishes per-tile boxes, centres and detect flags at frame end.
module red_target_tracker
    import target_pkg::*;
#(
    parameter int         H_RES      = 640,
    parameter int         V_RES      = 480,
    parameter logic [3:0] R_MIN      = R_MIN_DEF,
    parameter logic [3:0] G_MAX      = G_MAX_DEF,
    parameter logic [3:0] B_MAX      = B_MAX_DEF,
    parameter int         MIN_PIXELS = 64,
    parameter int         CNT_W      = 15
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 pixel_valid,
    input  logic [11:0]                          pixel_data,
    input  logic [9:0]                           x_pixel,
    input  logic [9:0]                           y_pixel,
    input  logic                                 frame_end,
    output logic [NUM_TARGETS-1:0][9:0]          aim_x_all,
    output logic [NUM_TARGETS-1:0][9:0]          aim_y_all,
    output logic [NUM_TARGETS-1:0]               aim_detected_all,
    output logic [NUM_TARGETS-1:0][COORD_W-1:0]  box_x_min_all,
    output logic [NUM_TARGETS-1:0][COORD_W-1:0]  box_x_max_all,
    output logic [NUM_TARGETS-1:0][COORD_W-1:0]  box_y_min_all,
    output logic [NUM_TARGETS-1:0][COORD_W-1:0]  box_y_max_all,
    output logic                                 frame_done
);

    logic                  s1_hit_d, s1_hit_q;
    logic [TILE_IDX_W-1:0] s1_tile_d, s1_tile_q;
    logic [9:0]            s1_x_d, s1_x_q;
    logic [9:0]            s1_y_d, s1_y_q;
    logic                  s1_fe_d, s1_fe_q;

    always_comb begin
        s1_hit_d  = pixel_valid
                 && (int'(x_pixel) < H_RES)
                 && (int'(y_pixel) < V_RES)
                 && is_red_rgb444(pixel_data, R_MIN, G_MAX, B_MAX);
        s1_tile_d = {grid_index(int'(y_pixel), TILE_H), grid_index(int'(x_pixel), TILE_W)};
        s1_x_d    = x_pixel;
        s1_y_d    = y_pixel;
        s1_fe_d   = frame_end;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_hit_q  <= 1'b0;
            s1_tile_q <= '0;
            s1_x_q    <= '0;
            s1_y_q    <= '0;
            s1_fe_q   <= 1'b0;
        end else begin
            s1_hit_q  <= s1_hit_d;
            s1_tile_q <= s1_tile_d;
            s1_x_q    <= s1_x_d;
            s1_y_q    <= s1_y_d;
            s1_fe_q   <= s1_fe_d;
        end
    end

    bbox_t            merged_bbox [NUM_TARGETS];
    logic [CNT_W-1:0] merged_cnt  [NUM_TARGETS];

    for (genvar k = 0; k < NUM_TARGETS; k++) begin : g_tile
        tile_bbox_accum #(
            .CNT_W (CNT_W)
        ) u_accum (
            .clk         (clk),
            .reset       (reset),
            .hit         (s1_hit_q && (s1_tile_q == TILE_IDX_W'(k))),
            .x           ({2'b00, s1_x_q}),
            .y           ({2'b00, s1_y_q}),
            .publish     (s1_fe_q),
            .merged_bbox (merged_bbox[k]),
            .merged_cnt  (merged_cnt[k])
        );
    end

    logic [NUM_TARGETS-1:0][9:0]         aim_x_d, aim_x_q;
    logic [NUM_TARGETS-1:0][9:0]         aim_y_d, aim_y_q;
    logic [NUM_TARGETS-1:0]              det_d, det_q;
    logic [NUM_TARGETS-1:0][COORD_W-1:0] bx_min_d, bx_min_q;
    logic [NUM_TARGETS-1:0][COORD_W-1:0] bx_max_d, bx_max_q;
    logic [NUM_TARGETS-1:0][COORD_W-1:0] by_min_d, by_min_q;
    logic [NUM_TARGETS-1:0][COORD_W-1:0] by_max_d, by_max_q;
    logic                                frame_done_d, frame_done_q;

    // Published values hold between frames; tiles below the pixel threshold read all-zero.
    always_comb begin
        aim_x_d      = aim_x_q;
        aim_y_d      = aim_y_q;
        det_d        = det_q;
        bx_min_d     = bx_min_q;
        bx_max_d     = bx_max_q;
        by_min_d     = by_min_q;
        by_max_d     = by_max_q;
        frame_done_d = s1_fe_q;
        if (s1_fe_q) begin
            for (int k = 0; k < NUM_TARGETS; k++) begin
                if (int'(merged_cnt[k]) >= MIN_PIXELS) begin
                    det_d[k]    = 1'b1;
                    bx_min_d[k] = merged_bbox[k].x_min;
                    bx_max_d[k] = merged_bbox[k].x_max;
                    by_min_d[k] = merged_bbox[k].y_min;
                    by_max_d[k] = merged_bbox[k].y_max;
                    aim_x_d[k]  = bbox_centre(merged_bbox[k].x_min, merged_bbox[k].x_max);
                    aim_y_d[k]  = bbox_centre(merged_bbox[k].y_min, merged_bbox[k].y_max);
                end else begin
                    det_d[k]    = 1'b0;
                    bx_min_d[k] = '0;
                    bx_max_d[k] = '0;
                    by_min_d[k] = '0;
                    by_max_d[k] = '0;
                    aim_x_d[k]  = '0;
                    aim_y_d[k]  = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            aim_x_q      <= '0;
            aim_y_q      <= '0;
            det_q        <= '0;
            bx_min_q     <= '0;
            bx_max_q     <= '0;
            by_min_q     <= '0;
            by_max_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            aim_x_q      <= aim_x_d;
            aim_y_q      <= aim_y_d;
            det_q        <= det_d;
            bx_min_q     <= bx_min_d;
            bx_max_q     <= bx_max_d;
            by_min_q     <= by_min_d;
            by_max_q     <= by_max_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign aim_x_all        = aim_x_q;
    assign aim_y_all        = aim_y_q;
    assign aim_detected_all = det_q;
    assign box_x_min_all    = bx_min_q;
    assign box_x_max_all    = bx_max_q;
    assign box_y_min_all    = by_min_q;
    assign box_y_max_all    = by_max_q;
    assign frame_done       = frame_done_q;

endmodule

// File: tb/tb_red_target_tracker.sv
// Self-checking bench for red_target_tracker: directed scenarios plus random frames,
// each compared against a per-pixel behavioural model of the tile bounding boxes.
module tb_red_target_tracker;

    logic              clk = 1'b0;
    logic              reset;
    logic              pixel_valid;
    logic [11:0]       pixel_data;
    logic [9:0]        x_pixel;
    logic [9:0]        y_pixel;
    logic              frame_end;
    logic [15:0][9:0]  aim_x_all;
    logic [15:0][9:0]  aim_y_all;
    logic [15:0]       aim_detected_all;
    logic [15:0][11:0] box_x_min_all;
    logic [15:0][11:0] box_x_max_all;
    logic [15:0][11:0] box_y_min_all;
    logic [15:0][11:0] box_y_max_all;
    logic              frame_done;

    always #5 clk = ~clk;

    red_target_tracker dut (
        .clk              (clk),
        .reset            (reset),
        .pixel_valid      (pixel_valid),
        .pixel_data       (pixel_data),
        .x_pixel          (x_pixel),
        .y_pixel          (y_pixel),
        .frame_end        (frame_end),
        .aim_x_all        (aim_x_all),
        .aim_y_all        (aim_y_all),
        .aim_detected_all (aim_detected_all),
        .box_x_min_all    (box_x_min_all),
        .box_x_max_all    (box_x_max_all),
        .box_y_min_all    (box_y_min_all),
        .box_y_max_all    (box_y_max_all),
        .frame_done       (frame_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int m_cnt  [16];
    int m_xmin [16];
    int m_xmax [16];
    int m_ymin [16];
    int m_ymax [16];

    logic [15:0][9:0]  exp_aim_x, exp_aim_y;
    logic [15:0]       exp_det;
    logic [15:0][11:0] exp_bx0, exp_bx1, exp_by0, exp_by1;

    function automatic void model_clear_frame();
        for (int k = 0; k < 16; k++) begin
            m_cnt[k]  = 0;
            m_xmin[k] = 4095;
            m_xmax[k] = 0;
            m_ymin[k] = 4095;
            m_ymax[k] = 0;
        end
    endfunction

    function automatic void model_clear_outputs();
        exp_aim_x = '0;
        exp_aim_y = '0;
        exp_det   = '0;
        exp_bx0   = '0;
        exp_bx1   = '0;
        exp_by0   = '0;
        exp_by1   = '0;
    endfunction

    function automatic void model_pixel(bit v, int x, int y, logic [11:0] d);
        int k;
        if (!v || x >= 640 || y >= 480) return;
        if (d[11:8] < 4'hA || d[7:4] > 4'h5 || d[3:0] > 4'h5) return;
        k = (y / 120) * 4 + (x / 160);
        if (m_cnt[k] < 32767) m_cnt[k]++;
        if (x < m_xmin[k]) m_xmin[k] = x;
        if (x > m_xmax[k]) m_xmax[k] = x;
        if (y < m_ymin[k]) m_ymin[k] = y;
        if (y > m_ymax[k]) m_ymax[k] = y;
    endfunction

    function automatic void model_publish();
        model_clear_outputs();
        for (int k = 0; k < 16; k++) begin
            if (m_cnt[k] >= 64) begin
                exp_det[k]   = 1'b1;
                exp_bx0[k]   = 12'(m_xmin[k]);
                exp_bx1[k]   = 12'(m_xmax[k]);
                exp_by0[k]   = 12'(m_ymin[k]);
                exp_by1[k]   = 12'(m_ymax[k]);
                exp_aim_x[k] = 10'((m_xmin[k] + m_xmax[k]) / 2);
                exp_aim_y[k] = 10'((m_ymin[k] + m_ymax[k]) / 2);
            end
        end
        model_clear_frame();
    endfunction

    task automatic drive(input bit v, input int x, input int y, input logic [11:0] d, input bit fe);
        @(negedge clk);
        pixel_valid = v;
        x_pixel     = 10'(x);
        y_pixel     = 10'(y);
        pixel_data  = d;
        frame_end   = fe;
        model_pixel(v, x, y, d);
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, 12'h000, 1'b0);
    endtask

    task automatic draw_block(input int x0, input int y0, input int w, input int h, input logic [11:0] d);
        for (int yy = y0; yy < y0 + h; yy++)
            for (int xx = x0; xx < x0 + w; xx++)
                drive(1'b1, xx, yy, d, 1'b0);
    endtask

    // Ends the frame and returns at the negedge where the publish is visible.
    task automatic end_frame(input bit v, input int x, input int y, input logic [11:0] d);
        drive(v, x, y, d, 1'b1);
        model_publish();
        idle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        pixel_valid = 1'b0;
        pixel_data  = '0;
        x_pixel     = '0;
        y_pixel     = '0;
        frame_end   = 1'b0;
        model_clear_frame();
        model_clear_outputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (frame_done !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset frame_done: got %b want 0", frame_done);
        end
        n_checks++;
        if ({aim_detected_all, aim_x_all, aim_y_all} !== '0) begin
            n_fail++; $display("[TB] FAIL reset aim: got %h want 0", {aim_detected_all, aim_x_all, aim_y_all});
        end
        n_checks++;
        if ({box_x_min_all, box_x_max_all, box_y_min_all, box_y_max_all} !== '0) begin
            n_fail++; $display("[TB] FAIL reset box: got %h want 0", {box_x_min_all, box_x_max_all, box_y_min_all, box_y_max_all});
        end
        drive(1'b0, 0, 0, 12'h000, 1'b1);
        model_publish();
        idle();
        n_checks++;
        if (frame_done !== 1'b0) begin
            n_fail++; $display("[TB] FAIL empty frame_done at +1: got %b want 0", frame_done);
        end
        @(negedge clk);
        n_checks++;
        if (frame_done !== 1'b1) begin
            n_fail++; $display("[TB] FAIL empty frame_done at +2: got %b want 1", frame_done);
        end
        n_checks++;
        if (aim_detected_all !== 16'h0000) begin
            n_fail++; $display("[TB] FAIL empty detected: got %h want 0000", aim_detected_all);
        end
        @(negedge clk);
        n_checks++;
        if (frame_done !== 1'b0) begin
            n_fail++; $display("[TB] FAIL empty frame_done at +3: got %b want 0", frame_done);
        end
    endtask

    task automatic test_single_block();
        draw_block(300, 200, 10, 10, 12'hF00);
        end_frame(1'b0, 0, 0, 12'h000);
        n_checks++;
        if (frame_done !== 1'b1) begin
            n_fail++; $display("[TB] FAIL block frame_done: got %b want 1", frame_done);
        end
        n_checks++;
        if (aim_detected_all !== 16'h0020 || aim_detected_all !== exp_det) begin
            n_fail++; $display("[TB] FAIL block detected: got %h want 0020", aim_detected_all);
        end
        n_checks++;
        if ({box_x_min_all[5], box_x_max_all[5], box_y_min_all[5], box_y_max_all[5]} !== {12'd300, 12'd309, 12'd200, 12'd209}) begin
            n_fail++; $display("[TB] FAIL block box5: got %0d/%0d/%0d/%0d want 300/309/200/209",
                               box_x_min_all[5], box_x_max_all[5], box_y_min_all[5], box_y_max_all[5]);
        end
        n_checks++;
        if (aim_x_all[5] !== 10'd304 || aim_y_all[5] !== 10'd204) begin
            n_fail++; $display("[TB] FAIL block aim5: got (%0d,%0d) want (304,204)", aim_x_all[5], aim_y_all[5]);
        end
        n_checks++;
        if ({box_x_min_all, box_x_max_all, box_y_min_all, box_y_max_all, aim_x_all, aim_y_all} !==
            {exp_bx0, exp_bx1, exp_by0, exp_by1, exp_aim_x, exp_aim_y}) begin
            n_fail++; $display("[TB] FAIL block all tiles: got %h want %h", {box_x_min_all, aim_x_all}, {exp_bx0, exp_aim_x});
        end
    endtask

    task automatic test_threshold_count();
        draw_block(10, 20, 7, 9, 12'hF00);
        end_frame(1'b0, 0, 0, 12'h000);
        n_checks++;
        if (aim_detected_all[0] !== 1'b0 || box_x_max_all[0] !== 12'd0 || aim_detected_all !== exp_det) begin
            n_fail++; $display("[TB] FAIL count63: got det %h xmax0 %0d want det %h xmax0 0", aim_detected_all, box_x_max_all[0], exp_det);
        end
        draw_block(10, 20, 7, 9, 12'hF00);
        end_frame(1'b1, 50, 50, 12'hF00);
        n_checks++;
        if (aim_detected_all !== 16'h0001 || aim_detected_all !== exp_det) begin
            n_fail++; $display("[TB] FAIL count64 merged: got %h want 0001", aim_detected_all);
        end
        n_checks++;
        if ({box_x_min_all[0], box_x_max_all[0], box_y_min_all[0], box_y_max_all[0]} !== {12'd10, 12'd50, 12'd20, 12'd50}) begin
            n_fail++; $display("[TB] FAIL count64 box0: got %0d/%0d/%0d/%0d want 10/50/20/50",
                               box_x_min_all[0], box_x_max_all[0], box_y_min_all[0], box_y_max_all[0]);
        end
    endtask

    task automatic test_rejects();
        draw_block(330, 130, 10, 10, 12'hF88);
        for (int i = 0; i < 80; i++) drive(1'b1, 640 + (i % 10), 10 + i / 10, 12'hF00, 1'b0);
        for (int i = 0; i < 80; i++) drive(1'b0, 500 + (i % 10), 10 + i / 10, 12'hF00, 1'b0);
        for (int i = 0; i < 80; i++) drive(1'b1, 5 + (i % 10), 480 + i / 10, 12'hF00, 1'b0);
        end_frame(1'b0, 0, 0, 12'h000);
        n_checks++;
        if (aim_detected_all !== 16'h0000 || aim_detected_all !== exp_det) begin
            n_fail++; $display("[TB] FAIL rejects detected: got %h want 0000", aim_detected_all);
        end
        n_checks++;
        if ({box_x_min_all, box_x_max_all, aim_x_all} !== '0) begin
            n_fail++; $display("[TB] FAIL rejects box/aim: got %h want 0", {box_x_min_all, box_x_max_all, aim_x_all});
        end
    endtask

    task automatic test_straddle();
        draw_block(155, 0, 10, 10, 12'hF00);
        end_frame(1'b0, 0, 0, 12'h000);
        n_checks++;
        if (aim_detected_all !== 16'h0000 || aim_detected_all !== exp_det) begin
            n_fail++; $display("[TB] FAIL straddle 10x10: got %h want 0000", aim_detected_all);
        end
        draw_block(155, 0, 10, 12, 12'hF00);
        end_frame(1'b0, 0, 0, 12'h000);
        n_checks++;
        if (aim_detected_all !== 16'h0000 || aim_detected_all !== exp_det) begin
            n_fail++; $display("[TB] FAIL straddle 10x12: got %h want 0000", aim_detected_all);
        end
        draw_block(155, 0, 14, 14, 12'hF00);
        end_frame(1'b0, 0, 0, 12'h000);
        n_checks++;
        if (aim_detected_all !== 16'h0003 || aim_detected_all !== exp_det) begin
            n_fail++; $display("[TB] FAIL straddle 14x14 detected: got %h want 0003", aim_detected_all);
        end
        n_checks++;
        if ({box_x_min_all[0], box_x_max_all[0], box_x_min_all[1], box_x_max_all[1]} !== {12'd155, 12'd159, 12'd160, 12'd168}) begin
            n_fail++; $display("[TB] FAIL straddle 14x14 x edges: got %0d/%0d %0d/%0d want 155/159 160/168",
                               box_x_min_all[0], box_x_max_all[0], box_x_min_all[1], box_x_max_all[1]);
        end
        n_checks++;
        if ({aim_x_all, aim_y_all} !== {exp_aim_x, exp_aim_y}) begin
            n_fail++; $display("[TB] FAIL straddle aim: got %h want %h", {aim_x_all, aim_y_all}, {exp_aim_x, exp_aim_y});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0]       saved_det;
        logic [15:0][11:0] saved_bx0;
        draw_block(330, 250, 9, 9, 12'hF00);
        drive(1'b0, 0, 0, 12'h000, 1'b1);
        model_publish();
        saved_det = exp_det;
        saved_bx0 = exp_bx0;
        drive(1'b0, 0, 0, 12'h000, 1'b1);
        model_publish();
        idle();
        n_checks++;
        if (frame_done !== 1'b1 || aim_detected_all !== saved_det || box_x_min_all !== saved_bx0) begin
            n_fail++; $display("[TB] FAIL b2b first publish: got done %b det %h want done 1 det %h", frame_done, aim_detected_all, saved_det);
        end
        @(negedge clk);
        n_checks++;
        if (frame_done !== 1'b1 || aim_detected_all !== 16'h0000 || aim_detected_all !== exp_det) begin
            n_fail++; $display("[TB] FAIL b2b second publish: got done %b det %h want done 1 det 0000", frame_done, aim_detected_all);
        end
        n_checks++;
        if ({box_x_min_all, box_x_max_all, box_y_min_all, box_y_max_all, aim_x_all, aim_y_all} !== '0) begin
            n_fail++; $display("[TB] FAIL b2b second box/aim: got %h want 0", {box_x_min_all, aim_x_all});
        end
        @(negedge clk);
        n_checks++;
        if (frame_done !== 1'b0) begin
            n_fail++; $display("[TB] FAIL b2b frame_done pulse: got %b want 0", frame_done);
        end
    endtask

    task automatic test_reset_mid_frame();
        draw_block(300, 200, 10, 5, 12'hF00);
        do_reset();
        n_checks++;
        if (aim_detected_all !== 16'h0000 || frame_done !== 1'b0) begin
            n_fail++; $display("[TB] FAIL midreset outputs: got det %h done %b want 0000 0", aim_detected_all, frame_done);
        end
        draw_block(300, 205, 10, 5, 12'hF00);
        end_frame(1'b0, 0, 0, 12'h000);
        n_checks++;
        if (aim_detected_all[5] !== 1'b0 || aim_detected_all !== exp_det) begin
            n_fail++; $display("[TB] FAIL midreset tile5: got %h want %h", aim_detected_all, exp_det);
        end
        draw_block(300, 200, 10, 10, 12'hF00);
        end_frame(1'b0, 0, 0, 12'h000);
        n_checks++;
        if (aim_detected_all !== 16'h0020 || {box_x_min_all[5], box_y_max_all[5]} !== {12'd300, 12'd209}) begin
            n_fail++; $display("[TB] FAIL midreset next frame: got det %h box %0d/%0d want 0020 300/209",
                               aim_detected_all, box_x_min_all[5], box_y_max_all[5]);
        end
    endtask

    task automatic test_random_frames();
        logic [11:0] palette [8];
        palette = '{12'hF00, 12'hA55, 12'hC32, 12'h955, 12'hF60, 12'hA06, 12'hFFF, 12'h0F0};
        for (int f = 0; f < 6; f++) begin
            for (int r = 0; r < 4; r++) begin
                int x0, y0, w, h;
                logic [11:0] col;
                x0  = $urandom_range(0, 700);
                y0  = $urandom_range(0, 500);
                w   = $urandom_range(3, 12);
                h   = $urandom_range(3, 12);
                col = palette[$urandom_range(0, 7)];
                for (int yy = y0; yy < y0 + h; yy++)
                    for (int xx = x0; xx < x0 + w; xx++)
                        drive(($urandom_range(0, 9) != 0), xx, yy, col, 1'b0);
            end
            for (int i = 0; i < 40; i++)
                drive(1'($urandom), $urandom_range(0, 1023), $urandom_range(0, 1023), 12'($urandom), 1'b0);
            end_frame(1'($urandom), $urandom_range(0, 639), $urandom_range(0, 479), palette[$urandom_range(0, 7)]);
            n_checks++;
            if (frame_done !== 1'b1 || aim_detected_all !== exp_det) begin
                n_fail++; $display("[TB] FAIL random frame %0d detected: got done %b det %h want det %h", f, frame_done, aim_detected_all, exp_det);
            end
            n_checks++;
            if ({box_x_min_all, box_x_max_all, box_y_min_all, box_y_max_all} !== {exp_bx0, exp_bx1, exp_by0, exp_by1}) begin
                n_fail++; $display("[TB] FAIL random frame %0d box: got %h want %h", f,
                                   {box_x_min_all, box_x_max_all}, {exp_bx0, exp_bx1});
            end
            n_checks++;
            if ({aim_x_all, aim_y_all} !== {exp_aim_x, exp_aim_y}) begin
                n_fail++; $display("[TB] FAIL random frame %0d aim: got %h want %h", f, {aim_x_all, aim_y_all}, {exp_aim_x, exp_aim_y});
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 32800; i++) drive(1'b1, 10, 10, 12'hF00, 1'b0);
        end_frame(1'b0, 0, 0, 12'h000);
        n_checks++;
        if (aim_detected_all !== 16'h0001 || aim_detected_all !== exp_det) begin
            n_fail++; $display("[TB] FAIL saturation detected: got %h want 0001", aim_detected_all);
        end
        n_checks++;
        if ({aim_x_all[0], aim_y_all[0], box_x_max_all[0]} !== {10'd10, 10'd10, 12'd10}) begin
            n_fail++; $display("[TB] FAIL saturation box0: got aim (%0d,%0d) xmax %0d want (10,10) 10",
                               aim_x_all[0], aim_y_all[0], box_x_max_all[0]);
        end
    endtask

    initial begin
        reset       = 1'b1;
        pixel_valid = 1'b0;
        pixel_data  = '0;
        x_pixel     = '0;
        y_pixel     = '0;
        frame_end   = 1'b0;
        model_clear_frame();
        model_clear_outputs();
        test_reset();
        test_single_block();
        test_threshold_count();
        test_rejects();
        test_straddle();
        test_back_to_back();
        test_reset_mid_frame();
        test_random_frames();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
